spi_flash_responder: RTL and testbench

Synthesizable SPI/QSPI flash target that answers the MCU's flash initiator (`sclk`, `cs_n`, `qdi`/`qdo`/`oe`) from an on-chip byte memory. It is used on boards without an external flash and in loopback benches to exercise the MCU's boot and fetch path. All SPI pins are oversampled in the `clk` domain. Only SPI mode 0 is supported: sample on the rising edge of `sclk`, drive on the falling edge.

---
 rtl/spi_flash_responder_if.sv | 29 ++
 rtl/spi_flash_responder.sv | 253 +++++++++++++++++++++++++
 tb/tb_spi_flash_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_flash_responder_if.sv
// SPI/QSPI flash pin bundle plus the byte-memory read port of the flash responder.
// Latency: none, wires only.
// Backpressure: none; the memory answers exactly 1 clk after mem_rd.
// Ports: sclk/cs_n/qdi from the initiator; qdo/oe back to the pads;
//        mem_addr/mem_rd to the byte memory; mem_data returned from it.
interface spi_flash_responder_if #(
  parameter int AW = 24
);
  logic          sclk;
  logic          cs_n;
  logic [3:0]    qdi;
  logic [3:0]    qdo;
  logic [3:0]    oe;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_data;

  // slave: the flash responder
  modport slave (
    input  sclk, cs_n, qdi, mem_data,
    output qdo, oe, mem_addr, mem_rd
  );

  // master: the flash initiator together with the backing memory
  modport master (
    output sclk, cs_n, qdi, mem_data,
    input  qdo, oe, mem_addr, mem_rd
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash target (03h/0Bh/6Bh read, 9Fh JEDEC ID, 05h status) served from a byte memory.
// Latency: 2-3 clk input sync, outputs update 1 clk after a detected sclk fall.
// Backpressure: none; the initiator paces everything through sclk, the memory answers in 1 clk.
// Ports: clk, rst_n (async active-low), bus (spi_flash_responder_if.slave).
// Build option: define FLASH_QUAD_EN to support the 6Bh quad output read; otherwise
// 6Bh is ignored, only lane 1 can ever be driven and the nibble datapath is absent.
module spi_flash_responder #(
  parameter int          AW       = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter int          DUMMY    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  spi_flash_responder_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_ID, S_STAT, S_IGNORE
  } state_t;

  localparam logic [7:0] DUMMY_LAST = 8'(DUMMY - 1);

  // synchronizer layout: {sclk, cs_n, qdi[3:0]}
  logic [5:0]    syn_meta_q, syn_meta_d;
  logic [5:0]    syn_q, syn_d;
  logic [1:0]    prev_q, prev_d;        // {sclk, cs_n} one cycle behind syn_q

  state_t        state_q, state_d;
  logic [7:0]    cnt_q, cnt_d;          // shift / dummy / bit-in-byte counter
  logic [7:0]    cmd_q, cmd_d;
  logic [AW-1:0] addr_q, addr_d;        // address of the most recently fetched byte
  logic [7:0]    cur_q, cur_d;          // remaining bits of the byte on the wire
  logic [7:0]    hold_q, hold_d;        // next byte, filled by the fetch/prefetch
  logic          pend_q, pend_d;        // mem_data is valid this cycle
  logic [1:0]    id_idx_q, id_idx_d;
  logic          mem_rd_q, mem_rd_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
`ifdef FLASH_QUAD_EN
  logic          quad_q, quad_d;
  logic [3:0]    qdo_q, qdo_d;
  logic [3:0]    oe_q, oe_d;
`else
  logic          qdo_q, qdo_d;          // lane 1 only
  logic          oe_q, oe_d;
`endif

  logic          sclk_s, cs_s, qd0;
  logic          rise, fall, cs_fall;
  logic [7:0]    id_byte;
  logic [7:0]    nb;                    // bits/nibble source for this fall
  logic          unused_qdi_hi;

  assign sclk_s  = syn_q[5];
  assign cs_s    = syn_q[4];
  assign qd0     = syn_q[0];
  assign rise    = sclk_s & ~prev_q[1];
  assign fall    = ~sclk_s & prev_q[1];
  assign cs_fall = ~cs_s & prev_q[0];

  // only lane 0 carries command/address bits; upper lanes are synchronized but unused
  assign unused_qdi_hi = ^syn_q[3:1];

  always_comb begin
    syn_meta_d = {bus.sclk, bus.cs_n, bus.qdi};
    syn_d      = syn_meta_q;
    prev_d     = syn_q[5:4];
    state_d    = state_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    cur_d      = cur_q;
    hold_d     = pend_q ? bus.mem_data : hold_q;
    pend_d     = mem_rd_q;
    id_idx_d   = id_idx_q;
    mem_rd_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    qdo_d      = qdo_q;
    oe_d       = oe_q;
`ifdef FLASH_QUAD_EN
    quad_d     = quad_q;
`endif

    case (id_idx_q)
      2'd0:    id_byte = JEDEC_ID[23:16];
      2'd1:    id_byte = JEDEC_ID[15:8];
      2'd2:    id_byte = JEDEC_ID[7:0];
      default: id_byte = 8'h00;
    endcase

    // At a byte boundary take a fresh byte; hold_d (not hold_q) lets data that
    // lands in this very cycle go straight out.
    nb = cur_q;
    if (cnt_q == 8'd0) begin
      case (state_q)
        S_DATA:  nb = hold_d;
        S_ID:    nb = id_byte;
        default: nb = 8'h00;
      endcase
    end

    if (cs_s) begin
      state_d  = S_IDLE;
      cnt_d    = 8'd0;
      oe_d     = '0;
      qdo_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cs_fall) begin
            state_d = S_CMD;
            cnt_d   = 8'd0;
          end
        end
        S_CMD: begin
          if (rise) begin
            cmd_d = {cmd_q[6:0], qd0};
            if (cnt_q == 8'd7) begin
              cnt_d    = 8'd0;
              id_idx_d = 2'd0;
`ifdef FLASH_QUAD_EN
              quad_d   = 1'b0;
`endif
              case (cmd_d)
                8'h03, 8'h0B: state_d = S_ADDR;
`ifdef FLASH_QUAD_EN
                8'h6B: begin
                  state_d = S_ADDR;
                  quad_d  = 1'b1;
                end
`endif
                8'h9F:   state_d = S_ID;
                8'h05:   state_d = S_STAT;
                default: state_d = S_IGNORE;
              endcase
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            // shifting through an AW-bit register drops the address bits above AW
            addr_d = {addr_q[AW-2:0], qd0};
            if (cnt_q == 8'd23) begin
              cnt_d      = 8'd0;
              mem_rd_d   = 1'b1;
              mem_addr_d = addr_d;
              if (cmd_q == 8'h03 || DUMMY == 0) state_d = S_DATA;
              else                              state_d = S_DUMMY;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_DUMMY: begin
          if (rise) begin
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = 8'd0;
              state_d = S_DATA;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end
        S_DATA, S_ID, S_STAT: begin
          if (fall) begin
            if (cnt_q == 8'd0) begin
              if (state_q == S_DATA) begin
                // prefetch the following byte while this one shifts out
                addr_d     = addr_q + 1'b1;
                mem_rd_d   = 1'b1;
                mem_addr_d = addr_q + 1'b1;
              end
              if (state_q == S_ID && id_idx_q != 2'd3) id_idx_d = id_idx_q + 2'd1;
            end
`ifdef FLASH_QUAD_EN
            if (quad_q) begin
              qdo_d = nb[7:4];
              oe_d  = 4'b1111;
              cur_d = {nb[3:0], 4'h0};
              cnt_d = (cnt_q == 8'd1) ? 8'd0 : cnt_q + 8'd1;
            end else begin
              qdo_d = {2'b00, nb[7], 1'b0};
              oe_d  = 4'b0010;
              cur_d = {nb[6:0], 1'b0};
              cnt_d = (cnt_q == 8'd7) ? 8'd0 : cnt_q + 8'd1;
            end
`else
            qdo_d = nb[7];
            oe_d  = 1'b1;
            cur_d = {nb[6:0], 1'b0};
            cnt_d = (cnt_q == 8'd7) ? 8'd0 : cnt_q + 8'd1;
`endif
          end
        end
        default: ;  // S_IGNORE: stay silent until cs_n rises
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      syn_meta_q <= 6'b01_0000;
      syn_q      <= 6'b01_0000;
      prev_q     <= 2'b01;
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      cmd_q      <= 8'd0;
      addr_q     <= '0;
      cur_q      <= 8'd0;
      hold_q     <= 8'd0;
      pend_q     <= 1'b0;
      id_idx_q   <= 2'd0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      qdo_q      <= '0;
      oe_q       <= '0;
`ifdef FLASH_QUAD_EN
      quad_q     <= 1'b0;
`endif
    end else begin
      syn_meta_q <= syn_meta_d;
      syn_q      <= syn_d;
      prev_q     <= prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      cur_q      <= cur_d;
      hold_q     <= hold_d;
      pend_q     <= pend_d;
      id_idx_q   <= id_idx_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      qdo_q      <= qdo_d;
      oe_q       <= oe_d;
`ifdef FLASH_QUAD_EN
      quad_q     <= quad_d;
`endif
    end
  end

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
`ifdef FLASH_QUAD_EN
  assign bus.qdo = qdo_q;
  assign bus.oe  = oe_q;
`else
  assign bus.qdo = {2'b00, qdo_q, 1'b0};
  assign bus.oe  = {2'b00, oe_q, 1'b0};
`endif

endmodule

// File: tb/tb_spi_flash_responder.sv
// Randomized bench for spi_flash_responder with a flash-level reference model.
// Latency: n/a. Backpressure: n/a.
// Expected per-rise pin states and memory fetch addresses are queued by the
// stimulus and popped by independent monitors on sclk rises and mem_rd strobes.
module tb_spi_flash_responder;

  localparam int          HALF  = 8;          // clk cycles per sclk half period
  localparam int          DUMMY = 8;
  localparam logic [23:0] JEDEC = 24'hEF4016;
`ifdef FLASH_QUAD_EN
  localparam bit QUAD = 1'b1;
`else
  localparam bit QUAD = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] oe;
    logic [3:0] dat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   rise_n = 0;
  logic rd_prev = 1'b0;

  exp_t        exp_q[$];
  logic [23:0] rdaddr_q[$];
  logic [7:0]  mem_ov [logic [23:0]];

  spi_flash_responder_if #(.AW(24)) bus ();

  spi_flash_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mem_val(input logic [23:0] a);
    if (mem_ov.exists(a)) return mem_ov[a];
    return (a[7:0] * 8'd37) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
  endfunction

  // Byte i of the response stream for a command starting at addr.
  function automatic logic [7:0] model_byte(input logic [7:0] cmd, input logic [23:0] addr, input int i);
    logic [23:0] id;
    id = JEDEC;
    if (cmd == 8'h9F) begin
      if (i == 0) return id[23:16];
      if (i == 1) return id[15:8];
      if (i == 2) return id[7:0];
      return 8'h00;
    end
    if (cmd == 8'h05) return 8'h00;
    return mem_val(addr + 24'(i));
  endfunction

  // byte memory: data one clk after the read strobe
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_data <= mem_val(bus.mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // pin monitor: every sclk rise inside a transaction is checked against the model
  always @(posedge bus.sclk) begin
    exp_t e;
    if (!bus.cs_n && rst_n) begin
      rise_n++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rise%0d: got oe=%b, expected no sclk rise", rise_n, bus.oe);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("rise%0d_oe_qdo", rise_n), {24'd0, bus.oe, bus.qdo & e.oe}, {24'd0, e.oe, e.dat & e.oe});
      end
    end
  end

  // memory-port monitor: each strobe must match the next expected fetch address
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mem_rd) begin
        if (rdaddr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_rd: got addr %0h, expected no read", bus.mem_addr);
        end else begin
          chk("mem_rd_addr", {7'd0, rd_prev, bus.mem_addr}, {8'd0, rdaddr_q.pop_front()});
        end
      end
      rd_prev = bus.mem_rd;
    end else begin
      rd_prev = 1'b0;
    end
  end

  task automatic half();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pulse(input logic d0, input bit last);
    bus.qdi = {3'($urandom_range(0, 7)), d0};
    half();
    bus.sclk = 1'b1;
    half();
    if (!last) bus.sclk = 1'b0;
  endtask

  // One transaction of 8 command bits, optional address/dummy, then ndata clocks.
  // Ends with cs_n rising while sclk is still high, or with a reset pulse.
  task automatic txn(input logic [7:0] cmd, input logic [23:0] addr, input int ndata, input bit by_reset);
    bit   has_addr, has_dummy, quad, rd, resp;
    int   fpb, npre, ntot;
    logic [7:0] b;
    logic d;
    exp_t e;
    has_addr  = (cmd == 8'h03) || (cmd == 8'h0B) || (cmd == 8'h6B);
    has_dummy = (cmd == 8'h0B) || (cmd == 8'h6B);
    quad      = (cmd == 8'h6B) && QUAD;
    rd        = has_addr && ((cmd != 8'h6B) || QUAD);
    resp      = rd || (cmd == 8'h9F) || (cmd == 8'h05);
    fpb       = quad ? 2 : 8;
    npre      = 8 + (has_addr ? 24 : 0) + (has_dummy ? DUMMY : 0);
    ntot      = npre + ndata;

    for (int i = 0; i < npre; i++) exp_q.push_back('0);
    for (int j = 0; j < ndata; j++) begin
      e = '0;
      if (resp) begin
        b = model_byte(cmd, addr, j / fpb);
        if (quad) e = {4'b1111, ((j % 2) == 0) ? b[7:4] : b[3:0]};
        else      e = {4'b0010, 2'b00, b[3'(7 - (j % 8))], 1'b0};
      end
      exp_q.push_back(e);
    end
    if (rd) begin
      for (int k = 0; k <= (ndata + fpb - 1) / fpb; k++) rdaddr_q.push_back(addr + 24'(k));
    end

    bus.cs_n = 1'b0;
    half();
    for (int i = 0; i < ntot; i++) begin
      if (i < 8)                  d = cmd[3'(7 - i)];
      else if (has_addr && i < 32) d = addr[5'(31 - i)];
      else                        d = 1'($urandom_range(0, 1));
      pulse(d, i == ntot - 1);
    end

    if (by_reset) begin
      rst_n = 1'b0;
      #1;
      chk("reset_mid_outputs", {19'd0, bus.oe, bus.qdo, bus.mem_rd, 4'd0}, 32'd0);
      @(negedge clk);
      bus.cs_n = 1'b1;
      bus.sclk = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
    end else begin
      bus.cs_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("cs_rise_oe_drop", {28'd0, bus.oe}, 32'd0);
      @(negedge clk);
      bus.sclk = 1'b0;
      half();
    end
  endtask

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got no end of run, expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [7:0] cmds [6];
    logic [7:0] c;
    cmds = '{8'h03, 8'h0B, 8'h6B, 8'h9F, 8'h05, 8'h5A};
    mem_ov[24'h000010] = 8'hA5;
    mem_ov[24'h000011] = 8'h3C;
    mem_ov[24'h000012] = 8'h7E;

    bus.sclk = 1'b0;
    bus.cs_n = 1'b1;
    bus.qdi  = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_qdo", {28'd0, bus.qdo}, 32'd0);
    chk("reset_oe", {28'd0, bus.oe}, 32'd0);
    chk("reset_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("reset_mem_addr", {8'd0, bus.mem_addr}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // sclk activity while deselected must be ignored
    for (int i = 0; i < 6; i++) begin
      bus.qdi  = 4'($urandom_range(0, 15));
      bus.sclk = ~bus.sclk;
      half();
    end
    chk("idle_toggle_outputs", {8'd0, bus.oe, bus.qdo, bus.mem_addr[15:0]}, 32'd0);

    txn(8'h03, 24'h000010, 24, 1'b0);   // A5 3C 7E, fetches 10..13
    txn(8'h6B, 24'hFFFFFF, 8, 1'b0);    // quad, wraps to address 0
    txn(8'h9F, 24'h000000, 40, 1'b0);   // EF 40 16 00 00
    txn(8'h0B, 24'h000010, 13, 1'b0);   // abandoned mid-byte
    txn(8'h05, 24'h000000, 16, 1'b0);   // status 00 00
    txn(8'h5A, 24'h000000, 24, 1'b0);   // unknown: silent
    txn(8'h03, 24'h000010, 11, 1'b1);   // reset during data
    txn(8'h03, 24'h000010, 24, 1'b0);   // clean after reset

    for (int n = 0; n < 8; n++) begin
      c = cmds[$urandom_range(0, 5)];
      txn(c, 24'($urandom), $urandom_range(1, 40), 1'b0);
    end

    repeat (10) @(negedge clk);
    chk("pin_queue_drained", exp_q.size(), 32'd0);
    chk("mem_queue_drained", rdaddr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
